noc_output_scheduler: RTL and testbench



---
 rtl/manycore_pkg.sv | 24 ++
 rtl/noc_output_scheduler_if.sv | 36 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/noc_output_scheduler.sv | 128 ++++++++++++
 tb/tb_noc_output_scheduler.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/manycore_pkg.sv
// Shared definitions for the manycore mesh router.
//   NPORTS        : number of router ports competing for one output
//   e_port        : router port index (EAST..LOCAL)
//   sched_state_e : state of one output-port wormhole scheduler
package manycore_pkg;

  localparam int unsigned NPORTS = 5;

  typedef enum logic [2:0] {
    EAST  = 3'd0,
    WEST  = 3'd1,
    NORTH = 3'd2,
    SOUTH = 3'd3,
    LOCAL = 3'd4
  } e_port;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    SIZE    = 2'd2,
    PAYLOAD = 2'd3
  } sched_state_e;

endpackage

// File: rtl/noc_output_scheduler_if.sv
// Handshake bundle between the input buffers / output link and one output scheduler.
//   req_i    : input n has a packet routed to this output
//   valid_i  : input n buffer head holds a flit
//   flit_i   : head flits, input n at [n*FLIT_WIDTH +: FLIT_WIDTH]
//   credit_i : downstream can take one flit this cycle
//   grant_o  : one-hot owner of the output
//   ack_o    : pop strobe back to the owning input
//   data_o   : outgoing flit, tx_o marks it valid
//   busy_o   : a packet is in flight
// The scheduler connects through the slave modport, the surrounding router through master.
interface noc_output_scheduler_if #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned NPORTS     = 5
);

  logic [NPORTS-1:0]            req_i;
  logic [NPORTS-1:0]            valid_i;
  logic [NPORTS*FLIT_WIDTH-1:0] flit_i;
  logic                         credit_i;
  logic [NPORTS-1:0]            grant_o;
  logic [NPORTS-1:0]            ack_o;
  logic [FLIT_WIDTH-1:0]        data_o;
  logic                         tx_o;
  logic                         busy_o;

  modport master (
    output req_i, valid_i, flit_i, credit_i,
    input  grant_o, ack_o, data_o, tx_o, busy_o
  );

  modport slave (
    input  req_i, valid_i, flit_i, credit_i,
    output grant_o, ack_o, data_o, tx_o, busy_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req_i : request vector (already masked by the caller)
//   ptr_i : index of the last winner; the search starts at ptr_i+1 and wraps
//   gnt_o : one-hot winner, zero when nothing is requested
module rr_arbiter #(
  parameter int unsigned NPORTS = 5,
  localparam int unsigned PtrW  = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [NPORTS-1:0] gnt_o
);

  logic            found;
  logic [PtrW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    // offset NPORTS brings the search back to the last winner itself, so it only
    // wins when it is the sole requester
    for (int unsigned off = 1; off <= NPORTS; off++) begin
      idx = PtrW'((32'(ptr_i) + off) % NPORTS);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_scheduler.sv
// Wormhole scheduler for one router output port.
// Arbitrates the input buffers round-robin, holds the grant for a whole packet
// (header flit, size flit, then 'size' payload flits) and forwards flits under
// credit-based flow control.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slave side of noc_output_scheduler_if (requests, head flits, credit in;
//           grant, pop strobes, outgoing flit, tx and busy out)
module noc_output_scheduler #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned NPORTS     = 5,
  parameter int unsigned SELF_PORT  = 4
) (
  input logic                   clock,
  input logic                   reset,
  noc_output_scheduler_if.slave bus
);

  import manycore_pkg::*;

  localparam int unsigned PtrW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  sched_state_e          state_q, state_d;
  logic [NPORTS-1:0]     grant_q, grant_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [FLIT_WIDTH-1:0] cnt_q, cnt_d;
  logic [FLIT_WIDTH-1:0] data_q, data_d;

  logic [NPORTS-1:0]     req_masked;
  logic [NPORTS-1:0]     arb_gnt;
  logic [PtrW-1:0]       gidx;
  logic [FLIT_WIDTH-1:0] gflit;
  logic                  gvalid;
  logic                  xfer;
  logic                  release_pkt;

  // A packet never turns back out of the port it came in on.
  assign req_masked = bus.req_i & ~(NPORTS'(1) << SELF_PORT);

  rr_arbiter #(
    .NPORTS (NPORTS)
  ) u_arb (
    .req_i (req_masked),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  // Select the owning input's head flit and valid bit.
  always_comb begin
    gidx   = '0;
    gflit  = '0;
    gvalid = 1'b0;
    for (int unsigned n = 0; n < NPORTS; n++) begin
      if (grant_q[n]) begin
        gidx   = PtrW'(n);
        gflit  = bus.flit_i[n*FLIT_WIDTH +: FLIT_WIDTH];
        gvalid = bus.valid_i[n];
      end
    end
  end

  assign xfer = (state_q != IDLE) && gvalid && bus.credit_i;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    release_pkt = 1'b0;
    data_d      = xfer ? gflit : data_q;

    case (state_q)
      IDLE: begin
        if (|req_masked) begin
          grant_d = arb_gnt;
          state_d = HDR;
        end
      end
      HDR: begin
        if (xfer) state_d = SIZE;
      end
      SIZE: begin
        if (xfer) begin
          cnt_d = gflit;
          if (gflit == '0) release_pkt = 1'b1;
          else             state_d     = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          cnt_d = cnt_q - FLIT_WIDTH'(1);
          if (cnt_q == FLIT_WIDTH'(1)) release_pkt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (release_pkt) begin
      state_d = IDLE;
      grant_d = '0;
      ptr_d   = gidx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PtrW'(NPORTS - 1);
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign bus.grant_o = grant_q;
  assign bus.ack_o   = xfer ? grant_q : '0;
  assign bus.tx_o    = xfer;
  // data_q holds the last flit sent so data_o is stable while idle or stalled
  assign bus.data_o  = xfer ? gflit : data_q;
  assign bus.busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_noc_output_scheduler.sv
// Scoreboard bench for noc_output_scheduler: packets are loaded into modelled input
// buffers, the expected flit stream is queued in arbitration order, and a monitor
// compares every transmitted flit against the queue head.
module tb_noc_output_scheduler;

  localparam int unsigned FW = 32;
  localparam int unsigned NP = 5;

  typedef struct packed {
    logic [2:0]    port;
    logic [FW-1:0] data;
  } exp_t;

  logic clock;
  logic reset;

  noc_output_scheduler_if #(.FLIT_WIDTH(FW), .NPORTS(NP)) bus ();

  noc_output_scheduler #(
    .FLIT_WIDTH (FW),
    .NPORTS     (NP),
    .SELF_PORT  (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [FW-1:0] bufq [NP][$];
  exp_t          exp_q [$];
  logic [NP-1:0] ack_seen;
  logic [NP-1:0] req_force;
  logic          cr;
  int            checks;
  int            failures;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic load(input int p, input logic [FW-1:0] hdr, input logic [FW-1:0] sz,
                      input logic [FW-1:0] base);
    exp_t e;
    bufq[p].push_back(hdr);
    e.port = 3'(p); e.data = hdr; exp_q.push_back(e);
    bufq[p].push_back(sz);
    e.data = sz; exp_q.push_back(e);
    for (int k = 0; k < int'(sz); k++) begin
      bufq[p].push_back(base + FW'(k));
      e.data = base + FW'(k);
      exp_q.push_back(e);
    end
  endtask

  task automatic refresh();
    for (int n = 0; n < NP; n++) begin
      bus.valid_i[n]         = (bufq[n].size() != 0);
      bus.flit_i[n*FW +: FW] = (bufq[n].size() != 0) ? bufq[n][0] : '0;
      bus.req_i[n]           = (bufq[n].size() != 0) || req_force[n];
    end
  endtask

  // Advance one clock: pop what was acked, present new heads, then settle to the negedge.
  task automatic tick();
    @(posedge clock);
    #1;
    for (int n = 0; n < NP; n++)
      if (ack_seen[n] && bufq[n].size() != 0) void'(bufq[n].pop_front());
    refresh();
    bus.credit_i = cr;
    @(negedge clock);
    #1;
  endtask

  task automatic run_pkt(input string name, input logic [NP-1:0] exp_g, input int exp_tx,
                         input int exp_busy);
    int            ntx;
    int            nb;
    logic [NP-1:0] first_g;
    bit            done;
    ntx = 0; nb = 0; first_g = '0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (bus.busy_o) begin
        nb++;
        if (bus.tx_o) ntx++;
        if (first_g == '0) first_g = bus.grant_o;
      end else if (nb != 0) begin
        done = 1'b1;
      end
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_grant"}, 32'(first_g), 32'(exp_g));
    chk({name, "_ntx"}, ntx, exp_tx);
    chk({name, "_nbusy"}, nb, exp_busy);
    chk({name, "_released"}, 32'(bus.grant_o), 32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      ack_seen = bus.ack_o;
      if (!reset) begin
        chk("inv_onehot", 32'($countones(bus.grant_o) <= 1), 32'd1);
        chk("inv_ack_sub", 32'(bus.ack_o & ~bus.grant_o), 32'd0);
        chk("inv_tx_ack", 32'(bus.tx_o), 32'(|bus.ack_o));
        if (bus.tx_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow got data=%h want no flit t=%0t", bus.data_o, $time);
          end else begin
            e = exp_q.pop_front();
            chk("sb_data", bus.data_o, e.data);
            chk("sb_ack", 32'(bus.ack_o), 32'(1) << e.port);
          end
        end
      end
    end
  endtask

  initial begin
    logic [NP-1:0] anyg;
    checks = 0; failures = 0;
    reset = 1'b1; cr = 1'b1; req_force = '0; ack_seen = '0;
    bus.req_i = '0; bus.valid_i = '0; bus.flit_i = '0; bus.credit_i = 1'b1;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_grant", 32'(bus.grant_o), 32'd0);
    chk("rst_ack", 32'(bus.ack_o), 32'd0);
    chk("rst_tx", 32'(bus.tx_o), 32'd0);
    chk("rst_data", bus.data_o, 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);

    // EAST packet of 3 payload flits: 1-cycle grant latency, 5 back-to-back flits
    load(0, 32'h0101, 32'd3, 32'hA);
    tick();
    chk("t1_lat", 32'(bus.grant_o), 32'd0);
    run_pkt("t1", 5'b00001, 5, 5);

    // WEST and NORTH together after EAST won: WEST first, then NORTH
    load(1, 32'h1111, 32'd1, 32'hB0);
    load(2, 32'h2222, 32'd1, 32'hC0);
    tick();
    run_pkt("t2w", 5'b00010, 3, 3);
    run_pkt("t2n", 5'b00100, 3, 3);

    // Requests from our own port are never granted; SOUTH with a zero-size packet
    req_force = 5'b10000;
    anyg = '0;
    repeat (8) begin
      tick();
      anyg |= bus.grant_o;
    end
    chk("t3_self", 32'(anyg), 32'd0);
    load(3, 32'h3333, 32'd0, 32'h0);
    tick();
    run_pkt("t3_south", 5'b01000, 2, 2);
    req_force = '0;

    // EAST size 4 with credit withdrawn for 3 cycles after the first payload flit
    load(0, 32'h4444, 32'd4, 32'hD0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_pre_tx", 32'(bus.tx_o), 32'd1);
    end
    cr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_stall_tx", 32'(bus.tx_o), 32'd0);
      chk("t4_stall_ack", 32'(bus.ack_o), 32'd0);
      chk("t4_stall_busy", 32'(bus.busy_o), 32'd1);
    end
    cr = 1'b1;
    run_pkt("t4", 5'b00001, 3, 3);

    // Reset mid-payload with 5 flits still owed, then EAST vs WEST from the reset pointer
    load(0, 32'h5555, 32'd8, 32'hE0);
    tick();
    repeat (6) tick();
    chk("t5_pre_tx", 32'(bus.tx_o), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_rst_grant", 32'(bus.grant_o), 32'd0);
    chk("t5_rst_ack", 32'(bus.ack_o), 32'd0);
    chk("t5_rst_tx", 32'(bus.tx_o), 32'd0);
    chk("t5_rst_data", bus.data_o, 32'd0);
    chk("t5_rst_busy", 32'(bus.busy_o), 32'd0);
    for (int n = 0; n < NP; n++) bufq[n].delete();
    exp_q.delete();
    ack_seen = '0;
    tick();
    chk("t5_hold_grant", 32'(bus.grant_o), 32'd0);
    reset = 1'b0;
    load(0, 32'h6666, 32'd0, 32'h0);
    load(1, 32'h7777, 32'd0, 32'h0);
    tick();
    run_pkt("t5e", 5'b00001, 2, 2);
    run_pkt("t5w", 5'b00010, 2, 2);

    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
